// File: rtl/flow_meter_pkg.sv
// Shared types and helpers for the multi-channel flow delta meter.
// Holds the FSM encoding, the channel-index width rule and the saturating add.
package flow_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

    // Wide enough for any accumulator this block is expected to carry.
    localparam int SAT_W = 64;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [SAT_W:0] sat_limit(input int unsigned acc_w);
        return ((SAT_W+1)'(1) << acc_w) - (SAT_W+1)'(1);
    endfunction

    function automatic logic sat_clips(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input int unsigned      acc_w);
        return ({1'b0, a} + {1'b0, b}) > sat_limit(acc_w);
    endfunction

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      acc_w);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = sat_limit(acc_w);
        if (sum > lim) begin
            return lim[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Period counter: counts enabled cycles and emits a one-cycle tick every TICK_DIV of them.
// The tick is decoded from the counter register so it lines up with the wrap edge.
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TICK_DIV - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/flow_delta_meter.sv
// Snapshots CHANNELS meter counts each period, then scans them one per cycle to
// produce wrap-safe deltas and saturating running totals, flagged by a valid strobe.
module flow_delta_meter
    import flow_meter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int ACC_WIDTH = 24,
    parameter int TICK_DIV  = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clear,
    input  logic [CHANNELS*WIDTH-1:0]     sample_in,
    output logic [CHANNELS*WIDTH-1:0]     delta_out,
    output logic [CHANNELS*ACC_WIDTH-1:0] total_out,
    output logic [CHANNELS-1:0]           overflow,
    output logic                          valid
);

    localparam int IDXW = idx_width(CHANNELS);

    state_e                r_state;
    logic [IDXW-1:0]       r_idx;
    logic                  r_primed;
    logic                  r_valid;
    logic [CHANNELS-1:0]   r_overflow;
    logic [WIDTH-1:0]      r_snap  [CHANNELS];
    logic [WIDTH-1:0]      r_prev  [CHANNELS];
    logic [WIDTH-1:0]      r_delta [CHANNELS];
    logic [ACC_WIDTH-1:0]  r_total [CHANNELS];

    logic                  w_run;
    logic                  w_tick;
    logic                  w_last_ch;
    logic                  w_clip;
    logic [WIDTH-1:0]      w_delta;
    logic [ACC_WIDTH-1:0]  w_sat;

    // The period only advances while idle, so a scan never overlaps the next tick.
    assign w_run = en && (r_state == ST_IDLE);

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_run),
        .i_clear (clear),
        .o_tick  (w_tick)
    );

    assign w_delta   = r_snap[r_idx] - r_prev[r_idx];
    assign w_sat     = ACC_WIDTH'(sat_add(SAT_W'(r_total[r_idx]), SAT_W'(w_delta), ACC_WIDTH));
    assign w_clip    = sat_clips(SAT_W'(r_total[r_idx]), SAT_W'(w_delta), ACC_WIDTH);
    assign w_last_ch = (r_idx == IDXW'(CHANNELS - 1));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign delta_out[g*WIDTH +: WIDTH]         = r_delta[g];
        assign total_out[g*ACC_WIDTH +: ACC_WIDTH] = r_total[g];
    end

    assign overflow = r_overflow;
    assign valid    = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_primed   <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_snap[i]  <= '0;
                r_prev[i]  <= '0;
                r_delta[i] <= '0;
                r_total[i] <= '0;
            end
        end else if (clear) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_primed   <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_delta[i] <= '0;
                r_total[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_snap[i] <= sample_in[i*WIDTH +: WIDTH];
                        end
                        r_idx   <= '0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_prev[r_idx] <= r_snap[r_idx];
                    if (r_primed) begin
                        r_delta[r_idx] <= w_delta;
                        r_total[r_idx] <= w_sat;
                        if (w_clip) begin
                            r_overflow[r_idx] <= 1'b1;
                        end
                    end else begin
                        r_delta[r_idx] <= '0;
                    end
                    // Raised on the way into PUBLISH so the strobe covers exactly that cycle.
                    if (w_last_ch) begin
                        r_valid <= r_primed;
                        r_state <= ST_PUBLISH;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_PUBLISH: begin
                    r_primed <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flow_delta_meter.sv
// Directed bench for flow_delta_meter with CHANNELS=4, WIDTH=8, ACC_WIDTH=10, TICK_DIV=16.
// Each scenario task drives its own vectors and compares against hand-computed values.
module tb_flow_delta_meter;

    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 4;
    localparam int ACC_WIDTH = 10;
    localparam int TICK_DIV  = 16;

    logic                          clk;
    logic                          rst;
    logic                          en;
    logic                          clear;
    logic [CHANNELS*WIDTH-1:0]     sample_in;
    logic [CHANNELS*WIDTH-1:0]     delta_out;
    logic [CHANNELS*ACC_WIDTH-1:0] total_out;
    logic [CHANNELS-1:0]           overflow;
    logic                          valid;

    logic [WIDTH-1:0] s [CHANNELS];
    int n_vec;
    int n_err;

    flow_delta_meter #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .ACC_WIDTH (ACC_WIDTH),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (clear),
        .sample_in (sample_in),
        .delta_out (delta_out),
        .total_out (total_out),
        .overflow  (overflow),
        .valid     (valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_samples();
        sample_in = {s[3], s[2], s[1], s[0]};
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (valid !== 1'b1 && n < budget);
    endtask

    task automatic run_quiet(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            step();
            if (valid !== 1'b0) hits++;
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clear = 1'b0;
        for (int i = 0; i < CHANNELS; i++) s[i] = '0;
        drive_samples();
        repeat (2) step();
        n_vec++; if (delta_out !== '0) begin n_err++; $display("FAIL reset_delta: got %0h expected 0", delta_out); end
        n_vec++; if (total_out !== '0) begin n_err++; $display("FAIL reset_total: got %0h expected 0", total_out); end
        n_vec++; if (overflow !== '0) begin n_err++; $display("FAIL reset_overflow: got %0h expected 0", overflow); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        rst = 1'b0;
    endtask

    task automatic test_basic_delta();
        int n;
        int hits;
        do_clear();
        s[0] = 8'd10; s[1] = 8'd250; s[2] = 8'd0; s[3] = 8'd33;
        drive_samples();
        run_quiet(21, hits);
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL basic_prime_no_valid: got %0d strobes expected 0", hits); end
        s[0] = 8'd25;
        drive_samples();
        wait_valid(60, n);
        n_vec++; if (n != 20) begin n_err++; $display("FAIL basic_valid_latency: got %0d cycles expected 20", n); end
        n_vec++; if (delta_out !== 32'h0000_000F) begin n_err++; $display("FAIL basic_delta: got %0h expected f", delta_out); end
        n_vec++; if (total_out !== 40'd15) begin n_err++; $display("FAIL basic_total: got %0h expected f", total_out); end
        n_vec++; if (overflow !== 4'b0000) begin n_err++; $display("FAIL basic_overflow: got %0b expected 0", overflow); end
        step();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_width: got %0b expected 0", valid); end
    endtask

    task automatic test_wrap();
        int n;
        s[1] = 8'd4;
        drive_samples();
        wait_valid(60, n);
        n_vec++; if (n != 20) begin n_err++; $display("FAIL wrap_latency: got %0d cycles expected 20", n); end
        n_vec++; if (delta_out !== 32'h0000_0A00) begin n_err++; $display("FAIL wrap_delta: got %0h expected a00", delta_out); end
        n_vec++; if (total_out !== 40'd10255) begin n_err++; $display("FAIL wrap_total: got %0h expected %0h", total_out, 40'd10255); end
        n_vec++; if (overflow !== 4'b0000) begin n_err++; $display("FAIL wrap_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_saturation();
        int n;
        int acc;
        int d;
        logic of;
        logic [ACC_WIDTH-1:0] t2;
        acc = 0;
        of  = 1'b0;
        for (int p = 1; p <= 7; p++) begin
            d = (p <= 6) ? 200 : 10;
            s[2] = s[2] + 8'(d);
            drive_samples();
            acc = acc + d;
            if (acc > 1023) begin
                acc = 1023;
                of  = 1'b1;
            end
            t2 = ACC_WIDTH'(acc);
            wait_valid(60, n);
            n_vec++; if (n != 21) begin n_err++; $display("FAIL sat_latency p%0d: got %0d expected 21", p, n); end
            n_vec++; if (delta_out !== {8'd0, 8'(d), 8'd0, 8'd0}) begin n_err++; $display("FAIL sat_delta p%0d: got %0h", p, delta_out); end
            n_vec++; if (total_out !== {10'd0, t2, 10'd10, 10'd15}) begin n_err++; $display("FAIL sat_total p%0d: got %0h expected %0h", p, total_out, {10'd0, t2, 10'd10, 10'd15}); end
            n_vec++; if (overflow !== {1'b0, of, 2'b00}) begin n_err++; $display("FAIL sat_overflow p%0d: got %0b expected %0b", p, overflow, {1'b0, of, 2'b00}); end
        end
    endtask

    task automatic test_clear_mid_scan();
        int n;
        int hits;
        s[0] = 8'd30;
        drive_samples();
        repeat (18) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_vec++; if (total_out !== '0) begin n_err++; $display("FAIL clear_total: got %0h expected 0", total_out); end
        n_vec++; if (delta_out !== '0) begin n_err++; $display("FAIL clear_delta: got %0h expected 0", delta_out); end
        n_vec++; if (overflow !== '0) begin n_err++; $display("FAIL clear_overflow: got %0b expected 0", overflow); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL clear_valid: got %0b expected 0", valid); end
        run_quiet(21, hits);
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL clear_prime_no_valid: got %0d strobes expected 0", hits); end
        s[3] = 8'd110;
        drive_samples();
        wait_valid(60, n);
        n_vec++; if (n != 20) begin n_err++; $display("FAIL clear_next_valid: got %0d cycles expected 20", n); end
        n_vec++; if (delta_out !== 32'h4D00_0000) begin n_err++; $display("FAIL clear_next_delta: got %0h expected 4d000000", delta_out); end
        n_vec++; if (total_out !== {10'd77, 30'd0}) begin n_err++; $display("FAIL clear_next_total: got %0h expected %0h", total_out, {10'd77, 30'd0}); end
    endtask

    task automatic test_enable();
        int n;
        int hits;
        en   = 1'b0;
        s[0] = 8'd33;
        drive_samples();
        run_quiet(3 * TICK_DIV, hits);
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL en_low_no_valid: got %0d strobes expected 0", hits); end
        en = 1'b1;
        run_quiet(17, hits);
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL en_early_valid: got %0d strobes expected 0", hits); end
        en = 1'b0;
        wait_valid(30, n);
        n_vec++; if (n != 3) begin n_err++; $display("FAIL en_drop_scan_latency: got %0d cycles expected 3", n); end
        n_vec++; if (delta_out !== 32'h0000_0003) begin n_err++; $display("FAIL en_drop_delta: got %0h expected 3", delta_out); end
        n_vec++; if (total_out !== {10'd77, 20'd0, 10'd3}) begin n_err++; $display("FAIL en_drop_total: got %0h expected %0h", total_out, {10'd77, 20'd0, 10'd3}); end
        run_quiet(30, hits);
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL en_low_after: got %0d strobes expected 0", hits); end
    endtask

    task automatic test_async_reset();
        int n;
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (delta_out !== '0) begin n_err++; $display("FAIL async_rst_delta: got %0h expected 0", delta_out); end
        n_vec++; if (total_out !== '0) begin n_err++; $display("FAIL async_rst_total: got %0h expected 0", total_out); end
        n_vec++; if (overflow !== '0) begin n_err++; $display("FAIL async_rst_overflow: got %0b expected 0", overflow); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        en  = 1'b1;
        wait_valid(100, n);
        n_vec++; if (n != 41) begin n_err++; $display("FAIL rst_release_two_ticks: got %0d cycles expected 41", n); end
        n_vec++; if (delta_out !== '0) begin n_err++; $display("FAIL rst_release_delta: got %0h expected 0", delta_out); end
        n_vec++; if (total_out !== '0) begin n_err++; $display("FAIL rst_release_total: got %0h expected 0", total_out); end
    endtask

    // sequence and report
    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b0; clear = 1'b0; sample_in = '0;
        test_reset();
        test_basic_delta();
        test_wrap();
        test_saturation();
        test_clear_mid_scan();
        test_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
